axis_vec_fork2: RTL and testbench

AXIS_VEC_FORK2 -- requirements
Module: axis_vec_fork2

---
 rtl/axis_vec_fork2.sv | 167 ++++++++++++++++
 tb/tb_axis_vec_fork2.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_vec_fork2.sv
// -----------------------------------------------------------------------------
// axis_vec_fork2
//
// Routes a stream of TILE_SIZE-lane vector beats to two independently
// back-pressured output streams (A and B). Each beat carries a 2-bit
// destination mask:
//   in_dest[0] -> stream A, in_dest[1] -> stream B, 2'b11 -> both (broadcast),
//   2'b00 -> accepted and dropped.
// Each output stream has its own DEPTH-entry circular FIFO. A stall on one
// output never blocks pops on the other. The input is accepted only when
// both FIFOs have room, so a broadcast beat can always land in both.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   rst_n            : asynchronous active-low reset; clears pointers, counts
//                      and every FIFO entry
//   in_valid/in_ready: input handshake. in_ready comes from the registered
//                      counts only.
//   in_dest          : destination mask for the current beat
//   in_vec           : input vector, lanes [TILE_SIZE-1:0]
//   a_valid/a_ready  : stream A handshake, a_vec is the FIFO A head entry
//   b_valid/b_ready  : stream B handshake, b_vec is the FIFO B head entry
//   a_count/b_count  : current occupancy of FIFO A / FIFO B, 0..DEPTH
//
// Parameters
//   TILE_SIZE  : lanes per vector beat
//   DATA_WIDTH : bits per lane
//   DEPTH      : entries per output FIFO. Must be a power of two and >= 2.
//                Pointers wrap through natural binary overflow.
// -----------------------------------------------------------------------------
module axis_vec_fork2 #(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,

    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [1:0]                            in_dest,
    input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  in_vec,

    output logic                                  a_valid,
    input  logic                                  a_ready,
    output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  a_vec,

    output logic                                  b_valid,
    input  logic                                  b_ready,
    output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]  b_vec,

    output logic [$clog2(DEPTH):0]                a_count,
    output logic [$clog2(DEPTH):0]                b_count
);

    // -------------------------------------------------------------------------
    // Derived widths
    // -------------------------------------------------------------------------
    localparam int PW = $clog2(DEPTH);   // pointer width
    localparam int CW = PW + 1;          // count width, holds 0..DEPTH

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
    localparam logic [PW-1:0] ONE_PTR    = PW'(1);

    typedef logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

    // -------------------------------------------------------------------------
    // Per-stream signals. Index 0 is stream A and index 1 is stream B. This
    // matches the bit order of in_dest, so one generate loop can build both
    // FIFOs.
    // -------------------------------------------------------------------------
    logic [1:0]          push;
    logic [1:0]          pop;
    logic [1:0]          head_valid;
    logic [1:0]          out_ready;
    logic [1:0]          has_room;
    logic [1:0][CW-1:0]  count_q;
    vec_t [1:0]          head_vec;

    logic                accept;

    assign out_ready = {b_ready, a_ready};

    // in_ready is based only on registered occupancy. A pop in the current
    // cycle cannot free space for a push in the same cycle, so no path runs
    // from a_ready/b_ready to in_ready. Both FIFOs must have room, even when
    // only one of them is targeted. This keeps broadcast simple and keeps the
    // handshake independent of in_dest.
    assign in_ready = has_room[0] && has_room[1];
    assign accept   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Output FIFOs
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [PW-1:0] wr_ptr_reg;
        logic [PW-1:0] rd_ptr_reg;
        logic [CW-1:0] count_reg;
        logic [CW-1:0] count_next;
        vec_t          mem_reg [DEPTH];

        // A beat with in_dest = 2'b00 is accepted but pushes neither FIFO.
        // In that case the pointers and counts do not change.
        assign push[gi]       = accept && in_dest[gi];
        assign head_valid[gi] = (count_reg != '0);
        assign pop[gi]        = head_valid[gi] && out_ready[gi];
        assign has_room[gi]   = (count_reg < FULL_COUNT);

        // Occupancy update. When a push and a pop happen in the same cycle,
        // the count stays the same while both pointers advance.
        always_comb begin
            count_next = count_reg;
            unique case ({push[gi], pop[gi]})
                2'b10:   count_next = count_reg + ONE_COUNT;
                2'b01:   count_next = count_reg - ONE_COUNT;
                default: count_next = count_reg;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
                end
                if (pop[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
                end
                count_reg <= count_next;
            end
        end

        // Storage is cleared on reset so that the head vector reads as zero
        // while the FIFO is empty after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_reg[i] <= '0;
                end
            end else if (push[gi]) begin
                mem_reg[wr_ptr_reg] <= in_vec;
            end
        end

        // The head entry is read straight from storage. It only changes when
        // the read pointer moves, that is, on a pop. So it stays stable while
        // valid is high and ready is low.
        assign head_vec[gi] = mem_reg[rd_ptr_reg];
        assign count_q[gi]  = count_reg;
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign a_valid = head_valid[0];
    assign a_vec   = head_vec[0];
    assign a_count = count_q[0];

    assign b_valid = head_valid[1];
    assign b_vec   = head_vec[1];
    assign b_count = count_q[1];

endmodule

// File: tb/tb_axis_vec_fork2.sv
module tb_axis_vec_fork2;
    localparam int TILE_SIZE  = 4;
    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 4;
    localparam int CW         = $clog2(DEPTH) + 1;

    typedef logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_dest  = 2'b00;
    vec_t          in_vec   = '0;
    logic          a_valid;
    logic          a_ready  = 1'b0;
    vec_t          a_vec;
    logic          b_valid;
    logic          b_ready  = 1'b0;
    vec_t          b_vec;
    logic [CW-1:0] a_count;
    logic [CW-1:0] b_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue per stream, in acceptance order.
    vec_t qa[$];
    vec_t qb[$];

    axis_vec_fork2 #(
        .TILE_SIZE (TILE_SIZE),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_dest (in_dest),
        .in_vec  (in_vec),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_vec   (a_vec),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_vec   (b_vec),
        .a_count (a_count),
        .b_count (b_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int base);
        vec_t v;
        for (int i = 0; i < TILE_SIZE; i++) v[i] = DATA_WIDTH'(base + i);
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < TILE_SIZE; i++) v[i] = DATA_WIDTH'($urandom);
        return v;
    endfunction

    // Drive one cycle from a negedge. Update the model at the rising edge
    // and return on the following negedge. The model decides acceptance and
    // pops from its own queue occupancy.
    task automatic cycle(input logic v, input logic [1:0] d, input vec_t x,
                         input logic ar, input logic br, output logic acc);
        logic exp_rdy;
        vec_t tmp;
        in_valid = v; in_dest = d; in_vec = x; a_ready = ar; b_ready = br;
        exp_rdy = (qa.size() < DEPTH) && (qb.size() < DEPTH);
        @(posedge clk);
        acc = v && exp_rdy;
        if (qa.size() != 0 && ar) tmp = qa.pop_front();
        if (qb.size() != 0 && br) tmp = qb.pop_front();
        if (acc && d[0]) qa.push_back(x);
        if (acc && d[1]) qb.push_back(x);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid: got %b want 0", a_valid); end
        n_cmp++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_valid: got %b want 0", b_valid); end
        n_cmp++; if (a_vec !== '0) begin n_err++; $display("FAIL reset_a_vec: got %h want 0", a_vec); end
        n_cmp++; if (b_vec !== '0) begin n_err++; $display("FAIL reset_b_vec: got %h want 0", b_vec); end
        n_cmp++; if (a_count !== '0 || b_count !== '0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", a_count, b_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_broadcast();
        logic acc;
        cycle(1'b1, 2'b11, mk(1), 1'b1, 1'b1, acc);
        n_cmp++; if (a_valid !== 1'b1 || a_vec !== mk(1)) begin n_err++; $display("FAIL bcast_a0: got %b %h want 1 %h", a_valid, a_vec, mk(1)); end
        n_cmp++; if (b_valid !== 1'b1 || b_vec !== mk(1)) begin n_err++; $display("FAIL bcast_b0: got %b %h want 1 %h", b_valid, b_vec, mk(1)); end
        n_cmp++; if (a_count !== CW'(1) || b_count !== CW'(1)) begin n_err++; $display("FAIL bcast_cnt0: got %0d/%0d want 1/1", a_count, b_count); end
        cycle(1'b1, 2'b11, mk(5), 1'b1, 1'b1, acc);
        n_cmp++; if (a_valid !== 1'b1 || a_vec !== mk(5)) begin n_err++; $display("FAIL bcast_a1: got %b %h want 1 %h", a_valid, a_vec, mk(5)); end
        n_cmp++; if (b_valid !== 1'b1 || b_vec !== mk(5)) begin n_err++; $display("FAIL bcast_b1: got %b %h want 1 %h", b_valid, b_vec, mk(5)); end
        n_cmp++; if (a_count !== CW'(1) || b_count !== CW'(1)) begin n_err++; $display("FAIL bcast_cnt1: got %0d/%0d want 1/1", a_count, b_count); end
        cycle(1'b0, 2'b00, '0, 1'b1, 1'b1, acc);
        n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_err++; $display("FAIL bcast_drain: got %b/%b want 0/0", a_valid, b_valid); end
        $display("test_broadcast done");
    endtask

    task automatic test_routing();
        logic acc;
        vec_t v[4];
        for (int i = 0; i < 4; i++) v[i] = rnd_vec();
        cycle(1'b1, 2'b01, v[0], 1'b1, 1'b1, acc);
        n_cmp++; if (a_valid !== 1'b1 || a_vec !== v[0] || b_valid !== 1'b0) begin n_err++; $display("FAIL route_v0: got %b %h %b want 1 %h 0", a_valid, a_vec, b_valid, v[0]); end
        cycle(1'b1, 2'b10, v[1], 1'b1, 1'b1, acc);
        n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b1 || b_vec !== v[1]) begin n_err++; $display("FAIL route_v1: got %b %b %h want 0 1 %h", a_valid, b_valid, b_vec, v[1]); end
        cycle(1'b1, 2'b00, v[2], 1'b1, 1'b1, acc);
        n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_count !== '0 || b_count !== '0) begin n_err++; $display("FAIL route_v2_drop: got %b %b %0d %0d want 0 0 0 0", a_valid, b_valid, a_count, b_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL route_v2_ready: got %b want 1", in_ready); end
        cycle(1'b1, 2'b11, v[3], 1'b1, 1'b1, acc);
        n_cmp++; if (a_vec !== v[3] || b_vec !== v[3] || a_valid !== 1'b1 || b_valid !== 1'b1) begin n_err++; $display("FAIL route_v3: got %h %h want %h", a_vec, b_vec, v[3]); end
        cycle(1'b0, 2'b00, '0, 1'b1, 1'b1, acc);
        n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_err++; $display("FAIL route_end: got %b/%b want 0/0", a_valid, b_valid); end
        $display("test_routing done");
    endtask

    task automatic test_backpressure();
        logic acc;
        vec_t bp[6];
        int idx = 0;
        for (int i = 0; i < 6; i++) bp[i] = rnd_vec();
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, 2'b11, bp[idx], 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        n_cmp++; if (b_count !== CW'(4) || b_vec !== bp[0]) begin n_err++; $display("FAIL bp_b_full: got %0d %h want 4 %h", b_count, b_vec, bp[0]); end
        n_cmp++; if (a_count !== CW'(1) || a_vec !== bp[3]) begin n_err++; $display("FAIL bp_a_head: got %0d %h want 1 %h", a_count, a_vec, bp[3]); end
        for (int c = 0; c < 2; c++) begin
            cycle(1'b1, 2'b11, bp[idx], 1'b1, 1'b0, acc);
            if (acc) idx++;
            n_cmp++; if (in_ready !== 1'b0 || b_count !== CW'(4) || a_count !== '0) begin n_err++; $display("FAIL bp_hold: got %b %0d %0d want 0 4 0", in_ready, b_count, a_count); end
        end
        cycle(1'b1, 2'b11, bp[idx], 1'b1, 1'b1, acc);
        if (acc) idx++;
        n_cmp++; if (in_ready !== 1'b1 || b_count !== CW'(3) || b_vec !== bp[1]) begin n_err++; $display("FAIL bp_release: got %b %0d %h want 1 3 %h", in_ready, b_count, b_vec, bp[1]); end
        for (int c = 0; c < 20; c++) begin
            cycle(idx < 6, 2'b11, bp[idx < 6 ? idx : 0], 1'b1, 1'b1, acc);
            if (acc) idx++;
            n_cmp++; if (b_valid !== (qb.size() != 0) || (qb.size() != 0 && b_vec !== qb[0])) begin n_err++; $display("FAIL bp_drain_b: got %b %h want %b", b_valid, b_vec, qb.size() != 0); end
            n_cmp++; if (a_valid !== (qa.size() != 0) || (qa.size() != 0 && a_vec !== qa[0])) begin n_err++; $display("FAIL bp_drain_a: got %b %h want %b", a_valid, a_vec, qa.size() != 0); end
            if (idx == 6 && qa.size() == 0 && qb.size() == 0) break;
        end
        n_cmp++; if (a_count !== '0 || b_count !== '0) begin n_err++; $display("FAIL bp_empty: got %0d/%0d want 0/0", a_count, b_count); end
        $display("test_backpressure done");
    endtask

    task automatic test_full_pushpop();
        logic acc;
        vec_t fp[16];
        int idx = 0;
        for (int i = 0; i < 16; i++) fp[i] = rnd_vec();
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, 2'b01, fp[idx], 1'b0, 1'b1, acc);
            if (acc) idx++;
        end
        n_cmp++; if (a_count !== CW'(4) || in_ready !== 1'b0 || a_vec !== fp[0]) begin n_err++; $display("FAIL fpp_full: got %0d %b %h want 4 0 %h", a_count, in_ready, a_vec, fp[0]); end
        cycle(1'b1, 2'b01, fp[idx], 1'b1, 1'b1, acc);
        if (acc) idx++;
        n_cmp++; if (a_count !== CW'(3) || in_ready !== 1'b1 || a_vec !== fp[1]) begin n_err++; $display("FAIL fpp_pop: got %0d %b %h want 3 1 %h", a_count, in_ready, a_vec, fp[1]); end
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, 2'b01, fp[idx], 1'($urandom_range(0, 1)), 1'b1, acc);
            if (acc) idx++;
            n_cmp++; if (a_count < CW'(3) || a_count > CW'(4)) begin n_err++; $display("FAIL fpp_range: got %0d want 3..4", a_count); end
            n_cmp++; if (a_vec !== qa[0] || a_count !== CW'(qa.size())) begin n_err++; $display("FAIL fpp_head: got %h %0d want %h %0d", a_vec, a_count, qa[0], qa.size()); end
        end
        for (int c = 0; c < 10; c++) begin
            if (qa.size() == 0) break;
            n_cmp++; if (a_valid !== 1'b1 || a_vec !== qa[0]) begin n_err++; $display("FAIL fpp_drain: got %b %h want 1 %h", a_valid, a_vec, qa[0]); end
            cycle(1'b0, 2'b00, '0, 1'b1, 1'b1, acc);
        end
        n_cmp++; if (a_count !== '0 || a_valid !== 1'b0) begin n_err++; $display("FAIL fpp_empty: got %0d %b want 0 0", a_count, a_valid); end
        $display("test_full_pushpop done");
    endtask

    task automatic test_reset_midstream();
        logic acc;
        vec_t r3;
        r3 = rnd_vec();
        cycle(1'b1, 2'b11, rnd_vec(), 1'b0, 1'b0, acc);
        cycle(1'b1, 2'b11, rnd_vec(), 1'b0, 1'b0, acc);
        cycle(1'b1, 2'b01, rnd_vec(), 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        n_cmp++; if (a_count !== CW'(3) || b_count !== CW'(2)) begin n_err++; $display("FAIL mid_pre: got %0d/%0d want 3/2", a_count, b_count); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b/%b want 0/0", a_valid, b_valid); end
        n_cmp++; if (a_count !== '0 || b_count !== '0) begin n_err++; $display("FAIL mid_count: got %0d/%0d want 0/0", a_count, b_count); end
        n_cmp++; if (a_vec !== '0 || b_vec !== '0) begin n_err++; $display("FAIL mid_vec: got %h/%h want 0/0", a_vec, b_vec); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", in_ready); end
        qa.delete();
        qb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 2'b11, r3, 1'b1, 1'b1, acc);
        n_cmp++; if (a_vec !== r3 || b_vec !== r3 || a_count !== CW'(1) || b_count !== CW'(1)) begin n_err++; $display("FAIL mid_post: got %h %h %0d %0d want %h 1 1", a_vec, b_vec, a_count, b_count, r3); end
        cycle(1'b0, 2'b00, '0, 1'b1, 1'b1, acc);
        n_cmp++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin n_err++; $display("FAIL mid_alone: got %b/%b want 0/0", a_valid, b_valid); end
        $display("test_reset_midstream done");
    endtask

    task automatic test_random();
        logic acc;
        logic exp_rdy;
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom), rnd_vec(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0 ? 1'b0 : 1'($urandom_range(0, 1)), acc);
            exp_rdy = (qa.size() < DEPTH) && (qb.size() < DEPTH);
            n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready, exp_rdy); end
            n_cmp++; if (a_count !== CW'(qa.size()) || b_count !== CW'(qb.size())) begin n_err++; $display("FAIL rnd_count c%0d: got %0d/%0d want %0d/%0d", c, a_count, b_count, qa.size(), qb.size()); end
            n_cmp++; if (a_valid !== (qa.size() != 0) || (qa.size() != 0 && a_vec !== qa[0])) begin n_err++; $display("FAIL rnd_a c%0d: got %b %h", c, a_valid, a_vec); end
            n_cmp++; if (b_valid !== (qb.size() != 0) || (qb.size() != 0 && b_vec !== qb[0])) begin n_err++; $display("FAIL rnd_b c%0d: got %b %h", c, b_valid, b_vec); end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_routing();
        test_backpressure();
        test_full_pushpop();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
